// File: rtl/bound_flasher_param.sv
// Parametrised bound flasher: drives a thermometer LED bar through the
// phases UP1 -> DN1 -> UP2 -> DN2 -> UP3 -> BLINK. In UP2 and UP3, flick
// kicks the bar back down at two set points. The bar can restart on its own.
module bound_flasher_param #(
    parameter int N_LED     = 16,
    parameter int B1        = 6,
    parameter int B2        = 11,
    parameter int LO2       = 5,
    parameter int KICK_A    = 6,
    parameter int KICK_B    = 11,
    parameter int BLINK_CNT = 1,
    parameter int TICK_DIV  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick,
    input  logic             auto_repeat,
    output logic [N_LED-1:0] LED,
    output logic             busy,
    output logic [2:0]       phase
);

    localparam int LW = $clog2(N_LED + 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = $clog2(2 * BLINK_CNT + 1);

    localparam logic [LW-1:0] B1_L     = LW'(B1);
    localparam logic [LW-1:0] B2_L     = LW'(B2);
    localparam logic [LW-1:0] LO2_L    = LW'(LO2);
    localparam logic [LW-1:0] KA_L     = LW'(KICK_A);
    localparam logic [LW-1:0] KB_L     = LW'(KICK_B);
    localparam logic [LW-1:0] TOP_L    = LW'(N_LED);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BC_LAST  = BW'(2 * BLINK_CNT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP1   = 3'd1,
        DN1   = 3'd2,
        UP2   = 3'd3,
        DN2   = 3'd4,
        UP3   = 3'd5,
        BLINK = 3'd6
    } state_t;

    state_t          state, state_n;
    logic [LW-1:0]   lit, lit_n;
    logic [PW-1:0]   pre, pre_n;
    logic [BW-1:0]   bc, bc_n;
    logic [N_LED-1:0] led_n;
    logic            tick;
    logic            kick;

    function automatic logic [N_LED-1:0] therm(input logic [LW-1:0] n);
        logic [N_LED-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N_LED; i++) begin
            r[i] = (i < 32'(n));
        end
        return r;
    endfunction

    assign tick = (pre == PRE_LAST);
    assign kick = flick && ((lit == KA_L) || (lit == KB_L));

    // Next-state, lit count, prescaler and blink counter; LED only moves on a step.
    always_comb begin
        state_n = state;
        lit_n   = lit;
        bc_n    = bc;
        led_n   = LED;
        pre_n   = (state == IDLE) ? '0 : (tick ? '0 : pre + 1'b1);
        if (state == IDLE) begin
            if (flick) begin
                state_n = UP1;
                lit_n   = '0;
                bc_n    = '0;
                led_n   = '0;
            end
        end else if (tick) begin
            case (state)
                UP1: begin
                    lit_n = lit + 1'b1;
                    if (lit + 1'b1 == B1_L) state_n = DN1;
                end
                DN1: begin
                    lit_n = lit - 1'b1;
                    if (lit - 1'b1 == '0) state_n = UP2;
                end
                UP2: begin
                    if (kick) begin
                        lit_n   = lit - 1'b1;
                        state_n = DN1;
                    end else begin
                        lit_n = lit + 1'b1;
                        if (lit + 1'b1 == B2_L) state_n = DN2;
                    end
                end
                DN2: begin
                    lit_n = lit - 1'b1;
                    if (lit - 1'b1 == LO2_L) state_n = UP3;
                end
                UP3: begin
                    if (kick) begin
                        lit_n   = lit - 1'b1;
                        state_n = DN2;
                    end else begin
                        lit_n = lit + 1'b1;
                        if (lit + 1'b1 == TOP_L) begin
                            state_n = BLINK;
                            bc_n    = '0;
                        end
                    end
                end
                BLINK: begin
                    if (bc == BC_LAST) begin
                        lit_n   = '0;
                        bc_n    = '0;
                        state_n = auto_repeat ? UP1 : IDLE;
                    end else begin
                        bc_n = bc + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            // Blink pattern follows the counter value before its increment.
            if (state == BLINK && bc != BC_LAST) led_n = bc[0] ? '1 : '0;
            else                                 led_n = therm(lit_n);
        end
    end

    // State and registered outputs, all updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            lit   <= '0;
            pre   <= '0;
            bc    <= '0;
            LED   <= '0;
            busy  <= 1'b0;
            phase <= 3'd0;
        end else begin
            state <= state_n;
            lit   <= lit_n;
            pre   <= pre_n;
            bc    <= bc_n;
            LED   <= led_n;
            busy  <= (state_n != IDLE);
            phase <= state_n;
        end
    end

endmodule
